lfsr_word_serializer: RTL and testbench

//  Downstream stage of the 26-bit LFSR generator. Captures one parallel LFSR state word q[N-1:0]
//  and shifts it out serially, MSB first, under a valid/ready bit handshake. Pulses word_done after
//  the last bit, keeps a wrapping count of words sent, and sets a sticky flag on an all-zero
//  (lock-up) word. Feeds the serial PRBS output pin/checker.

---
 rtl/lfsr_pkg.sv | 13 +
 rtl/lfsr_word_serializer_if.sv | 27 ++
 rtl/lfsr_word_serializer_piso_reg.sv | 27 ++
 rtl/lfsr_word_serializer.sv | 97 +++++++++
 tb/tb_lfsr_word_serializer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR word serializer slice.
package lfsr_pkg;

  localparam int LFSR_N    = 26;
  localparam int LFSR_CNTW = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

endpackage

// File: rtl/lfsr_word_serializer_if.sv
// Word-in / bit-out handshake bundle between LFSR, serializer and PRBS sink.
// Both sides use valid/ready: a transfer happens on a posedge where valid and ready are both high;
// valid and its payload hold until that transfer.
interface lfsr_word_serializer_if #(
  parameter int N = 26
) ();

  logic [N-1:0] word_in;
  logic         word_valid;
  logic         word_ready;
  logic         bit_out;
  logic         bit_valid;
  logic         bit_ready;
  logic         frame_start;
  logic         word_done;

  modport master (
    input  word_in, word_valid, bit_ready,
    output word_ready, bit_out, bit_valid, frame_start, word_done
  );

  modport slave (
    output word_in, word_valid, bit_ready,
    input  word_ready, bit_out, bit_valid, frame_start, word_done
  );

endinterface

// File: rtl/lfsr_word_serializer_piso_reg.sv
// Parallel-in serial-out register: load a word, shift left with zero fill, expose the MSB.
module piso_reg #(
  parameter int N = 26
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [N-1:0] i_data,
  output logic         o_msb
);

  logic [N-1:0] r_shreg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
    end else if (i_shift) begin
      r_shreg <= {r_shreg[N-2:0], 1'b0};
    end
  end

  assign o_msb = r_shreg[N-1];

endmodule

// File: rtl/lfsr_word_serializer.sv
// Captures one LFSR state word and shifts it out MSB first; counts words sent and flags
// all-zero (lock-up) words.
module lfsr_word_serializer
  import lfsr_pkg::*;
#(
  parameter int N     = LFSR_N,
  parameter int CNT_W = LFSR_CNTW
) (
  input  logic                  clk,
  input  logic                  reset,
  lfsr_word_serializer_if.master bus,
  output logic [CNT_W-1:0]      word_count,
  output logic                  lockup,
  output ser_state_t            o_dbg_state
);

  localparam int IDX_W = $clog2(N);

  ser_state_t       r_state;
  ser_state_t       w_next;
  logic [IDX_W-1:0] r_bit_idx;
  logic [CNT_W-1:0] r_word_count;
  logic             r_lockup;

  logic w_ready;
  logic w_bit_valid;
  logic w_frame_start;
  logic w_word_done;
  logic w_capture;
  logic w_accept;
  logic w_msb;

  // Ready is held low while reset is asserted so nothing is offered as accepted during reset.
  always_comb begin
    w_next        = r_state;
    w_ready       = 1'b0;
    w_bit_valid   = 1'b0;
    w_frame_start = 1'b0;
    w_word_done   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = reset;
        if (bus.word_valid && reset) w_next = SHIFT;
      end
      SHIFT: begin
        w_bit_valid   = 1'b1;
        w_frame_start = (r_bit_idx == IDX_W'(N - 1));
        if (bus.bit_ready && (r_bit_idx == '0)) w_next = DONE;
      end
      DONE: begin
        w_word_done = 1'b1;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_capture = w_ready && bus.word_valid;
  assign w_accept  = (r_state == SHIFT) && bus.bit_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_bit_idx    <= '0;
      r_word_count <= '0;
      r_lockup     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_bit_idx <= IDX_W'(N - 1);
        r_lockup  <= r_lockup | (bus.word_in == '0);
      end else if (w_accept && (r_bit_idx != '0)) begin
        r_bit_idx <= r_bit_idx - 1'b1;
      end
      if (r_state == DONE) r_word_count <= r_word_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  piso_reg #(.N(N)) u_piso (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_load  (w_capture),
    .i_shift (w_accept),
    .i_data  (bus.word_in),
    .o_msb   (w_msb)
  );

  assign bus.word_ready  = w_ready;
  assign bus.bit_valid   = w_bit_valid;
  assign bus.bit_out     = w_bit_valid & w_msb;
  assign bus.frame_start = w_frame_start;
  assign bus.word_done   = w_word_done;
  assign word_count      = r_word_count;
  assign lockup          = r_lockup;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_lfsr_word_serializer.sv
// Bench for lfsr_word_serializer: word driver, bit scoreboard, reset/lockup/wrap scenarios.
module tb_lfsr_word_serializer;
  import lfsr_pkg::*;

  localparam int N     = 26;
  localparam int CNT_W = 11;

  logic             clk;
  logic             reset;
  logic [CNT_W-1:0] word_count;
  logic             lockup;
  ser_state_t       dbg_state;

  lfsr_word_serializer_if #(.N(N)) bus ();

  lfsr_word_serializer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .word_count  (word_count),
    .lockup      (lockup),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_bits   = 0;
  int n_done   = 0;
  logic rdy_toggle = 1'b0;
  logic garble     = 1'b0;

  // scoreboard: {frame_start, bit} per expected accepted bit
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bit_ready driver: tied high, or toggling every cycle to create stalls
  initial begin
    bus.bit_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.bit_ready = rdy_toggle ? ~bus.bit_ready : 1'b1;
    end
  end

  // monitor
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic       prev_b = 1'b0;
  logic [1:0] exp_e;

  always @(negedge clk) begin
    if (reset && prev_v && !prev_r && bus.bit_valid)
      check("stall_hold", {31'd0, bus.bit_out}, {31'd0, prev_b});
    if (bus.bit_valid && bus.word_done) check("done_with_bit", 32'd1, 32'd0);
    if (bus.bit_valid && bus.bit_ready) begin
      if (exp_q.size() == 0) begin
        check("bit_unexpected", 32'd1, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("bit", {30'd0, bus.frame_start, bus.bit_out}, {30'd0, exp_e});
      end
      n_bits++;
    end
    if (bus.word_done) n_done++;
    prev_v <= bus.bit_valid;
    prev_r <= bus.bit_ready;
    prev_b <= bus.bit_out;
  end

  // driver tasks (called aligned to a negedge)
  task automatic start_word(input logic [N-1:0] w);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.word_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
    bus.word_valid = 1'b1;
    bus.word_in    = w;
    @(posedge clk);
    for (int i = N - 1; i >= 0; i--) exp_q.push_back({(i == N - 1), w[i]});
    #1;
    bus.word_valid = 1'b0;
  endtask

  task automatic finish_word(output int cyc);
    bit ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.word_done) begin
        ok = 1'b1;
        break;
      end
      if (garble) begin
        bus.word_valid = 1'($urandom_range(0, 1));
        bus.word_in    = N'($urandom);
      end
    end
    bus.word_valid = 1'b0;
    if (!ok) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("q_empty", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
  endtask

  int cyc;
  int b0;
  int d0;
  logic [N-1:0] rw;

  initial begin
    reset          = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_in    = '0;

    // 1: reset state
    repeat (2) @(negedge clk);
    check("rst_ready_low", {31'd0, bus.word_ready}, 32'd0);
    check("rst_bit_valid", {31'd0, bus.bit_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, bus.word_ready}, 32'd1);
    check("bit_valid_after_rst", {31'd0, bus.bit_valid}, 32'd0);
    check("count_after_rst", {21'd0, word_count}, 32'd0);
    check("lockup_after_rst", {31'd0, lockup}, 32'd0);
    check("done_after_rst", {31'd0, bus.word_done}, 32'd0);
    check("state_after_rst", {30'd0, dbg_state}, {30'd0, IDLE});

    // 5: reset while bit index 10 is presented
    start_word(26'h155AA33);
    b0 = n_bits;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (n_bits - b0 >= 10) break;
    end
    check("midword_bits", n_bits - b0, 32'd10);
    d0 = n_done;
    reset = 1'b0;
    @(negedge clk);
    check("abort_bit_valid", {31'd0, bus.bit_valid}, 32'd0);
    check("abort_done", {31'd0, bus.word_done}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, {30'd0, IDLE});
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready", {31'd0, bus.word_ready}, 32'd1);
    check("abort_no_done", n_done - d0, 32'd0);
    check("abort_count", {21'd0, word_count}, 32'd0);

    // 2: single word, bit_ready tied high
    start_word(26'h0000001);
    finish_word(cyc);
    check("done_latency", cyc, N + 1);
    check("count_w1", {21'd0, word_count}, 32'd1);
    check("lockup_w1", {31'd0, lockup}, 32'd0);

    // 3: alternating pattern with stalls
    rdy_toggle = 1'b1;
    b0 = n_bits;
    start_word(26'h2AAAAAA);
    finish_word(cyc);
    check("stall_bits", n_bits - b0, N);
    rdy_toggle = 1'b0;
    check("count_w2", {21'd0, word_count}, 32'd2);

    // 4: lock-up word, then all-ones word with busy-time garbage
    start_word(26'h0);
    finish_word(cyc);
    check("lockup_set", {31'd0, lockup}, 32'd1);
    check("count_w3", {21'd0, word_count}, 32'd3);
    garble = 1'b1;
    start_word(26'h3FFFFFF);
    finish_word(cyc);
    check("lockup_sticky", {31'd0, lockup}, 32'd1);
    check("count_w4", {21'd0, word_count}, 32'd4);

    // 6: counter wrap over 2048 back-to-back words with ignored valid pulses
    do_reset();
    check("count_cleared", {21'd0, word_count}, 32'd0);
    check("lockup_cleared", {31'd0, lockup}, 32'd0);
    for (int w = 1; w <= 2048; w++) begin
      rw = N'($urandom) | 26'h1;
      start_word(rw);
      finish_word(cyc);
      check("wrap_latency", cyc, N + 1);
      if (w == 2047) check("count_2047", {21'd0, word_count}, 32'd2047);
      if (w == 2048) check("count_wrap", {21'd0, word_count}, 32'd0);
    end
    garble = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
